// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding and
// the fetch FSM state encodings.
package if_stage_pkg;

  // addi x0, x0, 0 -- the canonical RV32I NOP placed in IF/ID bubbles
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_REQ   = 2'd0,
    IF_WAIT  = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset to RESET_PC, load a word-aligned redirect
// target, or advance by one instruction (modulo 2^32).
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        inc,
  output logic [31:0] pc
);

  // Redirect beats increment; the low two bits of a target are always cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc & 32'hFFFF_FFFC;
    end else if (inc) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register. One outstanding
// instruction-memory request at a time; a skid buffer catches a response
// that arrives while decode is stalled, and redirects flush IF/ID to a bubble.
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
);

  if_state_e   state;
  logic [31:0] pc;
  logic [31:0] skid;
  logic        deliver;
  logic [31:0] deliver_data;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect_i),
    .load_pc (redirect_pc_i),
    .inc     (deliver),
    .pc      (pc)
  );

  // Request is issued straight from REQ; a same-cycle redirect suppresses it
  assign imem_req_o  = (state == IF_REQ) && !redirect_i && !rst;
  assign imem_addr_o = pc;

  // An instruction moves into IF/ID this cycle either straight from memory
  // (WAIT) or from the skid buffer (HOLD), never while stalled or redirected
  always_comb begin
    deliver      = 1'b0;
    deliver_data = skid;
    if (!redirect_i && !stall_i) begin
      if (state == IF_WAIT && imem_rvalid_i) begin
        deliver      = 1'b1;
        deliver_data = imem_rdata_i;
      end else if (state == IF_HOLD) begin
        deliver = 1'b1;
      end
    end
  end

  // Fetch FSM and skid buffer capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_REQ;
      skid  <= '0;
    end else begin
      case (state)
        IF_REQ: begin
          state <= redirect_i ? IF_REQ : IF_WAIT;
        end
        IF_WAIT: begin
          if (redirect_i) begin
            // A response landing with the redirect is simply discarded;
            // otherwise the stale response still has to be drained
            state <= imem_rvalid_i ? IF_REQ : IF_DRAIN;
          end else if (imem_rvalid_i) begin
            if (stall_i) begin
              skid  <= imem_rdata_i;
              state <= IF_HOLD;
            end else begin
              state <= IF_REQ;
            end
          end
        end
        IF_HOLD: begin
          if (redirect_i || !stall_i) begin
            state <= IF_REQ;
          end
        end
        IF_DRAIN: begin
          // Leaving on rvalid even under redirect keeps DRAIN from waiting
          // on a response that has already been consumed
          if (imem_rvalid_i) begin
            state <= IF_REQ;
          end
        end
        default: begin
          state <= IF_REQ;
        end
      endcase
    end
  end

  // IF/ID register: redirect flushes, stall holds, otherwise load or bubble
  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      id_valid_o <= 1'b0;
      id_pc_o    <= '0;
      id_instr_o <= INST_NOP;
    end else if (!stall_i) begin
      if (deliver) begin
        id_valid_o <= 1'b1;
        id_pc_o    <= pc;
        id_instr_o <= deliver_data;
      end else begin
        id_valid_o <= 1'b0;
        id_pc_o    <= '0;
        id_instr_o <= INST_NOP;
      end
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage and IF/ID pipeline register for the 5-stage RV32I core. Owns the PC, fetches one instruction at a time from instruction memory over a request/response interface, and presents `id_pc_o`/`id_instr_o`/`id_valid_o` to the decode stage, where the immediate generator and decoder consume them. Honors hazard-unit stalls and branch/jump redirects from EX by flushing to a NOP bubble.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall_i` input 1: hazard unit; hold IF/ID contents and PC.
- `redirect_i` input 1: EX taken branch/jump; flush and refetch.
- `redirect_pc_i` input 32: redirect target; bits [1:0] ignored (forced 0).
- `imem_req_o` output 1: fetch request, accepted in the cycle asserted.
- `imem_addr_o` output 32: fetch address, always equals PC.
- `imem_rvalid_i` input 1: response valid, ≥1 cycle after request.
- `imem_rdata_i` input 32: instruction word, valid with `imem_rvalid_i`.
- `id_valid_o` output 1: IF/ID holds a real instruction.
- `id_pc_o` output 32: PC of `id_instr_o`.
- `id_instr_o` output 32: instruction to decode; NOP (32'h0000_0013) when invalid.

## Operation
- One outstanding request max. FSM states: REQ, WAIT, HOLD, DRAIN.
- REQ: `imem_req_o`=!redirect_i, addr=PC → WAIT (REQ if redirect).
- WAIT: on rvalid && !stall_i: IF/ID ← {1, PC, rdata}, PC+=4 → REQ. On rvalid && stall_i: capture rdata in skid buffer → HOLD.
- HOLD: when !stall_i, IF/ID ← buffer, PC+=4 → REQ.
- IF/ID update when !stall_i and no instruction delivered this cycle: bubble (valid=0, instr=NOP, pc=0). When stall_i: IF/ID holds.
- Redirect (priority over stall and everything else): IF/ID ← bubble; PC ← {redirect_pc_i[31:2],2'b00}. REQ→REQ (request suppressed); HOLD→REQ (buffer dropped); WAIT→DRAIN, or →REQ if rvalid same cycle (response discarded); DRAIN→DRAIN.
- DRAIN: `imem_req_o`=0; on rvalid discard data → REQ.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Unsolicited rvalid in REQ or HOLD is ignored.

## Timing
- Reset (cycle with rst=1): state=REQ, PC=RESET_PC, `imem_req_o`=0, id_valid_o=0, id_instr_o=NOP, id_pc_o=0, buffer cleared. First request the cycle after rst deasserts.
- `imem_req_o`/`imem_addr_o` combinational from state, PC, redirect_i; all IF/ID outputs registered.
- Best-case throughput: one instruction per 2 cycles with 1-cycle memory (REQ, WAIT).
- Fetch latency: rvalid in cycle N → `id_instr_o` valid in N+1 if unstalled.
- rst mid-operation: abandons any outstanding response; a late rvalid after reset arrives in REQ and is ignored.

## Structure
- `defines.v` gains: `INST_NOP` (32'h0000_0013), FSM state encodings (`IF_REQ`, `IF_WAIT`, `IF_HOLD`, `IF_DRAIN`, 2 bits).
- One sub-module: `pc_reg` (PC register with reset, load-redirect, increment-by-4 enable).
- IF/ID register, skid buffer and FSM live in `if_stage`.

## Test plan
- Reset release, memory returns 1-cycle responses 32'h00500093, 32'h00A00113 → id_pc_o 0 then 4, instructions in order, requests at addr 0, 4, 8.
- stall_i high 3 cycles while rvalid arrives with 32'h002081B3 → HOLD, IF/ID unchanged during stall, instruction appears with pc=4 the cycle after stall drops, PC then 8.
- redirect_i with redirect_pc_i=32'h0000_0103 while in WAIT, memory responds 2 cycles later → response discarded, bubble in IF/ID, next request addr 32'h0000_0100.
- redirect_i and rvalid in same WAIT cycle, stall_i also high → bubble, data dropped, next cycle requests redirect target.
- RESET_PC=32'hFFFF_FFFC → second request addr 32'h0000_0000.
- rst asserted in WAIT, rvalid arrives the cycle after rst drops → ignored; id_valid_o stays 0, request to RESET_PC issued.
